bus_arbiter: RTL

Round-robin arbiter sharing the Gecko5 system bus between up to eight bus masters, such as the JTAG DMA engine and the CPU bridge. It takes the one-cycle `requestTransaction` / `transactionGranted` handshake from each master and issues a one-hot grant pulse. It then tracks the granted master's transaction from `begin_transaction` to `end_transaction`. A watchdog aborts stalled transactions by driving `bus_error` and `end_transaction` onto the bus.

---
 rtl/bus_arbiter_pkg.sv | 28 ++
 rtl/bus_rr_picker.sv | 41 ++++
 rtl/bus_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_pkg
// Description : Shared types and constants for the Gecko5 bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int c_cnt_width = 16;
  localparam int c_id_width  = $clog2(MAX_MASTERS);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GRANT      = 3'd1,
    WAIT_BEGIN = 3'd2,
    BUSY       = 3'd3,
    ABORT_ERR  = 3'd4,
    ABORT_END  = 3'd5
  } arb_state_t;

  // Saturating increment: the watchdog counter must never wrap back to zero.
  function automatic logic [c_cnt_width-1:0] sat_inc(input logic [c_cnt_width-1:0] value);
    return (value == {c_cnt_width{1'b1}}) ? value : value + c_cnt_width'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : bus_rr_picker
// Description : Combinational round-robin winner selection, scanning upward
//               from last_id+1 and wrapping modulo NUM_MASTERS.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0] request,
  input  logic [c_id_width-1:0]  last_id,
  output logic [c_id_width-1:0]  winner_id,
  output logic                   winner_valid
);

  int w_idx;

  always_comb begin
    winner_id    = '0;
    winner_valid = 1'b0;
    w_idx        = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      w_idx = int'(last_id) + i;
      if (w_idx >= NUM_MASTERS) begin
        w_idx = w_idx - NUM_MASTERS;
      end
      // Constant-index inner scan keeps every bit select in range.
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!winner_valid && (j == w_idx) && request[j]) begin
          winner_id    = c_id_width'(j);
          winner_valid = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin Gecko5 system bus arbiter with transaction
//               tracking and a stall watchdog that aborts hung transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int BEGIN_WINDOW   = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clock,
  input  logic                   n_reset,
  input  logic [NUM_MASTERS-1:0] request,
  output logic [NUM_MASTERS-1:0] grant,
  input  logic                   begin_transactionIN,
  input  logic                   end_transactionIN,
  input  logic                   data_validIN,
  input  logic                   busyIN,
  output logic                   bus_errorOUT,
  output logic                   end_transactionOUT,
  output logic                   arb_busy,
  output logic [2:0]             granted_id
);

  localparam logic [c_cnt_width-1:0] c_begin_last   = c_cnt_width'(BEGIN_WINDOW - 1);
  localparam logic [c_cnt_width-1:0] c_timeout_last = c_cnt_width'(TIMEOUT_CYCLES - 1);
  localparam logic [c_id_width-1:0]  c_last_init    = c_id_width'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] c_one          = NUM_MASTERS'(1);

  arb_state_t                 r_state;
  logic [c_cnt_width-1:0]     r_count;
  logic [c_id_width-1:0]      r_last_id;
  logic [c_id_width-1:0]      r_granted_id;
  logic [NUM_MASTERS-1:0]     r_grant;
  logic                       r_bus_error;
  logic                       r_end_out;
  logic                       r_arb_busy;

  logic [c_id_width-1:0]      w_winner_id;
  logic                       w_winner_valid;
  logic [NUM_MASTERS-1:0]     w_winner_onehot;
  logic                       w_bus_active;

  bus_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_picker (
    .request      (request),
    .last_id      (r_last_id),
    .winner_id    (w_winner_id),
    .winner_valid (w_winner_valid)
  );

  assign w_winner_onehot = c_one << w_winner_id;
  assign w_bus_active    = data_validIN | busyIN;

  // Outputs are loaded on the edge that enters the corresponding state, so
  // each one is a pure register and mirrors the state it belongs to.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_last_id    <= c_last_init;
      r_granted_id <= '0;
      r_grant      <= '0;
      r_bus_error  <= 1'b0;
      r_end_out    <= 1'b0;
      r_arb_busy   <= 1'b0;
    end else begin
      r_grant     <= '0;
      r_bus_error <= 1'b0;
      r_end_out   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_winner_valid) begin
            r_state      <= GRANT;
            r_last_id    <= w_winner_id;
            r_granted_id <= w_winner_id;
            r_grant      <= w_winner_onehot;
            r_arb_busy   <= 1'b1;
          end
        end
        GRANT: begin
          r_state <= WAIT_BEGIN;
          r_count <= '0;
        end
        WAIT_BEGIN: begin
          // begin is tested first so it wins over window expiry
          if (begin_transactionIN) begin
            r_state <= BUSY;
            r_count <= '0;
          end else if (r_count >= c_begin_last) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_arb_busy <= 1'b0;
          end else begin
            r_count <= sat_inc(r_count);
          end
        end
        BUSY: begin
          if (end_transactionIN) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_arb_busy <= 1'b0;
          end else if (w_bus_active) begin
            r_count <= '0;
          end else if (r_count >= c_timeout_last) begin
            r_state     <= ABORT_ERR;
            r_bus_error <= 1'b1;
          end else begin
            r_count <= sat_inc(r_count);
          end
        end
        ABORT_ERR: begin
          r_state   <= ABORT_END;
          r_end_out <= 1'b1;
        end
        ABORT_END: begin
          r_state    <= IDLE;
          r_count    <= '0;
          r_arb_busy <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_count    <= '0;
          r_arb_busy <= 1'b0;
        end
      endcase
    end
  end

  assign grant              = r_grant;
  assign bus_errorOUT       = r_bus_error;
  assign end_transactionOUT = r_end_out;
  assign arb_busy           = r_arb_busy;
  assign granted_id         = 3'(r_granted_id);

endmodule
`default_nettype wire
